psram_bram_responder: RTL and testbench

Responder side of the PSRAM user-port protocol used by the CPU memory bridge: accepts `cmd`/`cmd_en` requests with 4-beat 64-bit bursts and answers them from on-chip block RAM. It emulates the PSRAM HS controller user interface, including calibration delay, read latency and masked write bursts. It drops in place of the external PSRAM controller for simulation and for bring-up builds without PSRAM. The CPU-side cache and wait logic runs unmodified against it.

---
 rtl/psram_bram_responder.sv | 219 +++++++++++++++++++++
 tb/tb_psram_bram_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_bram_responder.sv
// psram_bram_responder: block-RAM stand-in for the PSRAM HS controller user port.
// Takes cmd/cmd_en requests for 4-beat 64-bit bursts and answers them from on-chip RAM,
// reproducing the calibration delay, read latency and write recovery of the real part.
//
// Ports:
//   clk_mem        memory-domain clock, rising edge
//   n_reset        synchronous active-low reset (RAM contents survive it)
//   cmd            1 = write, 0 = read, sampled with cmd_en
//   cmd_en         one-cycle command strobe
//   addr           burst address, line index = addr[LINE_BITS+4:5], other bits ignored
//   wr_data        write beat, sampled on the cmd_en cycle and the three following cycles
//   data_mask      per-byte-lane mask for the current write beat, 1 = lane not written
//   rd_data        read beat, holds its last value while rd_data_valid = 0
//   rd_data_valid  high for 4 consecutive cycles per read
//   init_calib     calibration done
//   busy           command in progress, cmd_en not accepted
//   cmd_drop       sticky flag: a cmd_en was ignored
module psram_bram_responder #(
   parameter int unsigned LINE_BITS    = 8,
   parameter int unsigned CALIB_CYCLES = 64,
   parameter int unsigned RD_LATENCY   = 12,
   parameter int unsigned WR_RECOVERY  = 4
) (
   input  logic        clk_mem,
   input  logic        n_reset,
   input  logic        cmd,
   input  logic        cmd_en,
   input  logic [20:0] addr,
   input  logic [63:0] wr_data,
   input  logic [7:0]  data_mask,
   output logic [63:0] rd_data,
   output logic        rd_data_valid,
   output logic        init_calib,
   output logic        busy,
   output logic        cmd_drop
);

   localparam int unsigned WordBits = LINE_BITS + 2;
   localparam int unsigned Depth    = 1 << WordBits;

   localparam logic [15:0] CalibLast = 16'(CALIB_CYCLES - 1);
   localparam logic [15:0] WrLast    = 16'(WR_RECOVERY - 1);
   // The RAM has one cycle of read latency, so beat 0 is issued one cycle early.
   localparam logic [15:0] RdLast    = 16'(RD_LATENCY - 2);

   typedef enum logic [2:0] {
      StCalib,
      StIdle,
      StWrite,
      StWrRecov,
      StRdWait,
      StRdBurst
   } state_e;

   state_e                 state_q, state_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [1:0]             beat_q, beat_d;
   logic [LINE_BITS-1:0]   line_q, line_d;
   logic                   calib_q, calib_d;
   logic                   busy_q, busy_d;
   logic                   drop_q, drop_d;
   logic                   valid_q, valid_d;
   logic [63:0]            rd_data_q;

   logic                   mem_we;
   logic [WordBits-1:0]    mem_waddr;
   logic                   rd_en;
   logic [WordBits-1:0]    rd_addr;
   logic [LINE_BITS-1:0]   addr_line;

   logic [63:0]            mem [Depth];

   assign addr_line = addr[LINE_BITS+4:5];

   // Offset and alias bits of the address are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^{addr[20:LINE_BITS+5], addr[4:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      line_d    = line_q;
      calib_d   = calib_q;
      busy_d    = busy_q;
      drop_d    = drop_q;
      valid_d   = valid_q;
      mem_we    = 1'b0;
      mem_waddr = {line_q, beat_q};
      rd_en     = 1'b0;
      rd_addr   = {line_q, beat_q + 2'd1};

      if (cmd_en && (state_q != StIdle)) begin
         drop_d = 1'b1;
      end

      case (state_q)
         StCalib: begin
            if (cnt_q == CalibLast) begin
               state_d = StIdle;
               calib_d = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StIdle: begin
            if (cmd_en) begin
               line_d = addr_line;
               busy_d = 1'b1;
               cnt_d  = '0;
               beat_d = 2'd0;
               if (cmd) begin
                  // Beat 0 is written on the strobe cycle itself.
                  mem_we    = 1'b1;
                  mem_waddr = {addr_line, 2'd0};
                  beat_d    = 2'd1;
                  state_d   = StWrite;
               end else begin
                  state_d = StRdWait;
               end
            end
         end
         StWrite: begin
            mem_we = 1'b1;
            if (beat_q == 2'd3) begin
               cnt_d = '0;
               if (WR_RECOVERY == 0) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end else begin
                  state_d = StWrRecov;
               end
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         StWrRecov: begin
            if (cnt_q == WrLast) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StRdWait: begin
            if (cnt_q == RdLast) begin
               rd_en   = 1'b1;
               rd_addr = {line_q, 2'd0};
               valid_d = 1'b1;
               beat_d  = 2'd0;
               state_d = StRdBurst;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StRdBurst: begin
            // beat_q is the beat currently on rd_data; fetch the next one.
            if (beat_q == 2'd3) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               rd_en   = 1'b1;
               valid_d = 1'b1;
               beat_d  = beat_q + 2'd1;
            end
         end
         default: begin
            state_d = StCalib;
         end
      endcase
   end

   always_ff @(posedge clk_mem) begin
      if (!n_reset) begin
         state_q   <= StCalib;
         cnt_q     <= '0;
         beat_q    <= '0;
         line_q    <= '0;
         calib_q   <= 1'b0;
         busy_q    <= 1'b1;
         drop_q    <= 1'b0;
         valid_q   <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         calib_q <= calib_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
         valid_q <= valid_d;
         if (rd_en) begin
            rd_data_q <= mem[rd_addr];
         end
      end
   end

   // No reset on the array: contents persist across n_reset.
   always_ff @(posedge clk_mem) begin
      if (n_reset && mem_we) begin
         for (int i = 0; i < 8; i++) begin
            if (!data_mask[i]) begin
               mem[mem_waddr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = valid_q;
   assign init_calib    = calib_q;
   assign busy          = busy_q;
   assign cmd_drop      = drop_q;

endmodule

// File: tb/tb_psram_bram_responder.sv
// Testbench for psram_bram_responder: directed scenarios plus randomized write/read bursts,
// checked against a line-array reference model and the cycle timeline of the port protocol.
module tb_psram_bram_responder;

   localparam int unsigned LineBits = 8;
   localparam int unsigned Calib    = 64;
   localparam int unsigned RdLat    = 12;
   localparam int unsigned WrRec    = 4;
   localparam int unsigned NumLines = 1 << LineBits;

   logic        clk_mem = 1'b0;
   logic        n_reset;
   logic        cmd;
   logic        cmd_en;
   logic [20:0] addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;
   logic        init_calib;
   logic        busy;
   logic        cmd_drop;

   always #5 clk_mem = ~clk_mem;

   psram_bram_responder #(
      .LINE_BITS    (LineBits),
      .CALIB_CYCLES (Calib),
      .RD_LATENCY   (RdLat),
      .WR_RECOVERY  (WrRec)
   ) dut (
      .clk_mem       (clk_mem),
      .n_reset       (n_reset),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .init_calib    (init_calib),
      .busy          (busy),
      .cmd_drop      (cmd_drop)
   );

   logic [63:0] model [NumLines*4];
   bit          written [NumLines];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        exp_drop;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_mem);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_mem);
   endtask

   function automatic int line_of(input logic [20:0] a);
      return int'((a >> 5) % NumLines);
   endfunction

   // Calibration from the first n_reset = 1 cycle; optional stray cmd_en at cycle drop_at.
   task automatic run_calib(input int drop_at);
      n_reset = 1'b1;
      for (int k = 0; k <= int'(Calib); k++) begin
         cmd_en = (k == drop_at);
         cmd    = 1'($urandom);
         mid();
         check_val("calib_done", 64'(init_calib), 64'(k >= int'(Calib)));
         check_val("calib_busy", 64'(busy), 64'(k < int'(Calib)));
         check_val("calib_drop", 64'(cmd_drop), 64'(exp_drop));
         if (k == 0) begin
            check_val("calib_valid0", 64'(rd_data_valid), 64'd0);
            check_val("calib_rdata0", rd_data, 64'd0);
         end
         if (k == drop_at) exp_drop = 1'b1;
         next_cycle();
      end
      cmd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_en = 1'b0;
         mid();
         check_val("idle_busy", 64'(busy), 64'd0);
         check_val("idle_valid", 64'(rd_data_valid), 64'd0);
         next_cycle();
      end
   endtask

   task automatic do_write(input logic [20:0] a, input logic [255:0] d, input logic [31:0] m);
      int ln;
      ln = line_of(a);
      for (int k = 0; k < 4; k++) begin
         cmd_en    = (k == 0);
         cmd       = 1'b1;
         addr      = (k == 0) ? a : 21'($urandom);
         wr_data   = d[64*k +: 64];
         data_mask = m[8*k +: 8];
         mid();
         check_val(k == 0 ? "wr_accept_busy" : "wr_beat_busy", 64'(busy), 64'(k != 0));
         for (int j = 0; j < 8; j++) begin
            if (!m[8*k+j]) model[ln*4+k][8*j +: 8] = d[64*k+8*j +: 8];
         end
         next_cycle();
      end
      cmd_en    = 1'b0;
      wr_data   = {$urandom, $urandom};
      data_mask = 8'($urandom);
      for (int r = 0; r < int'(WrRec); r++) begin
         mid();
         check_val("wr_recov_busy", 64'(busy), 64'd1);
         next_cycle();
      end
   endtask

   task automatic do_read(input logic [20:0] a, input bit inject);
      int ln;
      ln     = line_of(a);
      cmd_en = 1'b1;
      cmd    = 1'b0;
      addr   = a;
      mid();
      check_val("rd_accept_busy", 64'(busy), 64'd0);
      next_cycle();
      addr = 21'($urandom);
      for (int t = 1; t <= int'(RdLat) + 3; t++) begin
         cmd_en = inject && (t == int'(RdLat) + 2);
         cmd    = 1'($urandom);
         mid();
         check_val("rd_valid", 64'(rd_data_valid), 64'(t >= int'(RdLat)));
         check_val("rd_busy", 64'(busy), 64'd1);
         if (t >= int'(RdLat)) check_val("rd_beat", rd_data, model[ln*4 + t - int'(RdLat)]);
         if (cmd_en) exp_drop = 1'b1;
         next_cycle();
      end
      cmd_en = 1'b0;
      mid();
      check_val("rd_end_valid", 64'(rd_data_valid), 64'd0);
      check_val("rd_end_busy", 64'(busy), 64'd0);
      check_val("rd_hold", rd_data, model[ln*4 + 3]);
      check_val("rd_end_drop", 64'(cmd_drop), 64'(exp_drop));
      next_cycle();
   endtask

   initial begin
      logic [255:0] d;
      logic [31:0]  m;
      logic [20:0]  a;
      int           ln;

      n_reset   = 1'b0;
      cmd_en    = 1'b0;
      cmd       = 1'b0;
      addr      = '0;
      wr_data   = '0;
      data_mask = '0;
      exp_drop  = 1'b0;
      for (int i = 0; i < int'(NumLines); i++) written[i] = 1'b0;

      repeat (3) @(posedge clk_mem);
      #1;
      mid();
      check_val("rst_rdata", rd_data, 64'd0);
      check_val("rst_valid", 64'(rd_data_valid), 64'd0);
      check_val("rst_calib", 64'(init_calib), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd1);
      check_val("rst_drop", 64'(cmd_drop), 64'd0);
      next_cycle();

      run_calib(10);

      // Incrementing pattern on line 3, read back-to-back after recovery.
      for (int k = 0; k < 4; k++) d[64*k +: 64] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
      do_write(21'(3 << 5), d, 32'h0);
      written[3] = 1'b1;
      do_read(21'(3 << 5), 1'b0);

      // Only lane 0 of beat 1 written.
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      d[127:64] = 64'hFFFFFFFFFFFFFFFF;
      do_write(21'(3 << 5), d, 32'hFFFFFEFF);
      do_read(21'(3 << 5), 1'b0);
      check_val("masked_beat1", model[3*4+1], 64'h0F0E0D0C0B0A09FF);

      // Aliased read of line 5.
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_write(21'((5 << 5) | 5'h1F), d, 32'h0);
      written[5] = 1'b1;
      idle(1);
      do_read(21'h0000A0 + 21'(1 << (LineBits + 5)), 1'b0);

      // Randomized bursts on random lines with random alias/offset bits.
      for (int it = 0; it < 8; it++) begin
         ln = int'($urandom_range(0, NumLines - 1));
         a  = 21'($urandom);
         a  = (a & ~21'((NumLines - 1) << 5)) | 21'(ln << 5);
         if (!written[ln]) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            do_write(a, d, 32'h0);
            written[ln] = 1'b1;
         end
         d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         m = $urandom;
         do_write(a, d, m);
         idle(int'($urandom_range(0, 2)));
         do_read(a, 1'b0);
         idle(int'($urandom_range(0, 1)));
      end

      // Reset during read beat 1, then recalibrate and verify RAM survived.
      cmd_en = 1'b1;
      cmd    = 1'b0;
      addr   = 21'(3 << 5);
      mid();
      check_val("rr_accept_busy", 64'(busy), 64'd0);
      next_cycle();
      cmd_en = 1'b0;
      for (int t = 1; t <= int'(RdLat) + 1; t++) begin
         if (t == int'(RdLat) + 1) begin
            n_reset = 1'b0;
            cmd_en  = 1'b1;
         end
         mid();
         check_val("rr_valid", 64'(rd_data_valid), 64'(t >= int'(RdLat)));
         if (t >= int'(RdLat)) check_val("rr_beat", rd_data, model[3*4 + t - int'(RdLat)]);
         next_cycle();
      end
      cmd_en   = 1'b0;
      exp_drop = 1'b0;
      run_calib(-1);
      do_read(21'(3 << 5), 1'b0);
      do_read(21'h0000A0, 1'b0);

      // Stray command during read beat 2 is dropped, burst completes, nothing executed.
      do_read(21'(5 << 5), 1'b1);
      check_val("drop_set", 64'(exp_drop), 64'd1);
      do_read(21'(5 << 5), 1'b0);
      do_read(21'(3 << 5), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
